fetch_queue_unit: RTL

- Parametrised instruction-fetch front end for the pipelined core. Replaces the bare PC + adder + PC mux + IF/ID pairing.
- Owns the fetch PC and issues requests to a 1-cycle-latency instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, which decouples fetch from ID stalls.
- Services branch/jump redirects from the MEM stage by flushing the queue and squashing any in-flight request.

---
 rtl/fetch_queue_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency memory reads,
// and buffers returned instructions with their PCs in a DEPTH-entry circular queue.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       stall,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic                       inst_valid,
  output logic [XLEN-1:0]            inst_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] issue_pc;
  logic            inflight;
  logic            squash;

  logic            pop;
  logic            push;
  logic [CW:0]     used;
  logic [CW:0]     limit;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & ~stall & ~redirect;
  assign push       = inflight & ~squash & ~redirect;

  // Credit check: entries held plus the one in flight must leave room after this cycle's pop.
  assign used     = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit    = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
  assign imem_req = ~clr & ~redirect & (used < limit);

  assign imem_addr = fetch_pc;
  assign inst_out  = inst_valid ? inst_q[rd_ptr] : '0;
  assign pc_out    = inst_valid ? pc_q[rd_ptr]   : '0;
  assign occupancy = count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc <= RESET_PC;
      issue_pc <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (redirect) begin
        // A return landing in the redirect cycle is already lost to the flush;
        // squash guards the cycle after so nothing stale can slip in.
        fetch_pc <= redirect_pc;
        squash   <= inflight;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        squash <= 1'b0;
        if (imem_req) begin
          fetch_pc <= fetch_pc + XLEN'(PC_STEP);
          issue_pc <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= issue_pc;
    end
  end

endmodule
